// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_pkg.sv - shared state enum and code width helper
package gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_pkg;

    // One launch/measure pass walks LAUNCH -> CAP -> SYNC -> ACC.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_CAP    = 3'd2,
        S_SYNC   = 3'd3,
        S_ACC    = 3'd4,
        S_FIN    = 3'd5
    } cal_state_e;

    // Width of a tap count in the range 0..ntaps inclusive.
    function automatic int cw_of(input int ntaps);
        return $clog2(ntaps + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_if.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_if.sv - chain/control signal bundle for the calibrator
interface gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_if
    import gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_pkg::*;
#(
    parameter int NTAPS = 32,
    parameter int CW    = cw_of(NTAPS)
);
    logic             START;
    logic [NTAPS-1:0] TAP;
    logic             LAUNCH;
    logic             BUSY;
    logic             DONE;
    logic [CW-1:0]    CODE;
    logic             SAT;

    // Requester side: issues runs and presents the chain taps.
    modport master (
        output START, TAP,
        input  LAUNCH, BUSY, DONE, CODE, SAT
    );

    // Calibrator side.
    modport slave (
        input  START, TAP,
        output LAUNCH, BUSY, DONE, CODE, SAT
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_lcnt.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_lcnt.sv - leading-match tap counter
module gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_lcnt
    import gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_pkg::*;
#(
    parameter int NTAPS = 32,
    parameter int CW    = cw_of(NTAPS)
) (
    input  logic [NTAPS-1:0] cap_i,
    input  logic             level_i,
    output logic [CW-1:0]    cnt_o,
    output logic             all_match_o
);

    // Count taps from TAP[0] upward until the first one that has not yet
    // switched to the launch level; bubbles above that point are ignored.
    always_comb begin
        logic run;
        cnt_o = '0;
        run   = 1'b1;
        for (int i = 0; i < NTAPS; i++) begin
            if (run && (cap_i[i] == level_i)) begin
                cnt_o = cnt_o + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
        all_match_o = run;
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_cal.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_cal.sv - delay-line calibration controller top
module gf180mcu_fd_sc_mcu7t5v0__dlyline_cal
    import gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_pkg::*;
#(
    parameter int NTAPS    = 32,
    parameter int AVG_LOG2 = 2
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_if.slave bus
);

    localparam int CW = cw_of(NTAPS);
    localparam int AW = CW + AVG_LOG2;
    localparam int ML = AVG_LOG2 + 1;
    localparam logic [ML-1:0] M_CNT = ML'(1 << AVG_LOG2);

    cal_state_e       state_q;
    logic             launch_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    code_q;
    logic             sat_q;
    logic             sat_run_q;
    logic [AW-1:0]    acc_q;
    logic [ML-1:0]    meas_q;
    logic [NTAPS-1:0] cap1_q;
    logic [NTAPS-1:0] cap2_q;

    logic [CW-1:0]    cnt;
    logic             all_match;
    logic [AW-1:0]    acc_d;
    logic [ML-1:0]    meas_d;

    gf180mcu_fd_sc_mcu7t5v0__dlyline_cal_lcnt #(
        .NTAPS (NTAPS),
        .CW    (CW)
    ) u_lcnt (
        .cap_i       (cap2_q),
        .level_i     (launch_q),
        .cnt_o       (cnt),
        .all_match_o (all_match)
    );

    // The accumulator is sized for M * NTAPS, so this sum cannot wrap.
    assign acc_d  = acc_q + AW'(cnt);
    assign meas_d = meas_q + ML'(1);

    // Run sequencer: launch, capture one period later, resynchronise, accumulate.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            launch_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            code_q    <= '0;
            sat_q     <= 1'b0;
            sat_run_q <= 1'b0;
            acc_q     <= '0;
            meas_q    <= '0;
            cap1_q    <= '0;
            cap2_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        busy_q    <= 1'b1;
                        acc_q     <= '0;
                        meas_q    <= '0;
                        sat_run_q <= 1'b0;
                        state_q   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    launch_q <= ~launch_q;
                    state_q  <= S_CAP;
                end
                S_CAP: begin
                    cap1_q  <= bus.TAP;
                    state_q <= S_SYNC;
                end
                S_SYNC: begin
                    cap2_q  <= cap1_q;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    acc_q  <= acc_d;
                    meas_q <= meas_d;
                    if (all_match) begin
                        sat_run_q <= 1'b1;
                    end
                    state_q <= (meas_d == M_CNT) ? S_FIN : S_LAUNCH;
                end
                S_FIN: begin
                    code_q  <= CW'(acc_q >> AVG_LOG2);
                    sat_q   <= sat_run_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.LAUNCH = launch_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.CODE   = code_q;
    assign bus.SAT    = sat_q;

endmodule
